// File: rtl/ins_cache_pkg.sv
// ins_cache_pkg: shared definitions for the instruction cache slice.
//   - ic_state_e : controller states (IC_IDLE, IC_MISS)
//   - LINES_DEF  : default number of 64-bit lines
//   - LINE_BYTES : bytes per cache line
//   - sel_word() : picks the 32-bit word of a line addressed by pc[2]
package ins_cache_pkg;

    localparam int LINES_DEF  = 32;
    localparam int LINE_BYTES = 8;

    typedef enum logic [0:0] {
        IC_IDLE = 1'b0,
        IC_MISS = 1'b1
    } ic_state_e;

    // Word select inside a line: the low word sits at the lower address.
    function automatic logic [31:0] sel_word(input logic [63:0] line, input logic hi);
        logic [31:0] w;
        if (hi) begin
            w = line[63:32];
        end else begin
            w = line[31:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/ins_cache_array.sv
// ins_cache_array: valid/tag/data storage for the direct-mapped cache.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits only)
//   rd_idx        : combinational read index
//   rd_valid/tag/data : contents of the addressed line
//   we, wr_idx, wr_tag, wr_data : single write port, sets the valid bit
module ins_cache_array
    import ins_cache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 29 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [63:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data
);

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [63:0]      data_r [LINES];

    // Combinational read port.
    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

    // Valid bits: cleared by reset, set by a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
        end else if (we) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; they are qualified by valid_r.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped instruction cache between fetch and memory controller.
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global enable, all state holds while low
//   clear           : pipeline flush, aborts an outstanding miss
//   if_req, if_pc   : fetch request / word-aligned address (sampled when if_ready)
//   if_ready        : cache idle and able to accept a request
//   ins_valid, ins_out : one-cycle response pulse and instruction
//   mem_fetch_sig, mem_fetch_addr : level line request and aligned line address
//   mem_fetch_done, mem_fetch_data : fill-complete pulse and 64-bit line data
module ins_cache
    import ins_cache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic        mem_fetch_sig,
    output logic [31:0] mem_fetch_addr,
    input  logic        mem_fetch_done,
    input  logic [63:0] mem_fetch_data
);

    localparam int TAG_W = 29 - IDX_W;

    ic_state_e        state_r;
    logic             ins_valid_r;
    logic [31:0]      ins_out_r;
    logic             mem_fetch_sig_r;
    logic [31:0]      mem_fetch_addr_r;
    logic [31:0]      miss_pc_r;

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             rd_valid_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic [63:0]      rd_data_s;
    logic             hit_s;
    logic             fill_s;

    assign lk_idx_s = if_pc[3+IDX_W-1:3];
    assign lk_tag_s = if_pc[31:3+IDX_W];
    assign hit_s    = rd_valid_s && (rd_tag_s == lk_tag_s);
    // A fill is taken on the same edge that samples done, even alongside clear.
    assign fill_s   = rdy && (state_r == IC_MISS) && mem_fetch_done;

    assign if_ready       = (state_r == IC_IDLE);
    assign ins_valid      = ins_valid_r;
    assign ins_out        = ins_out_r;
    assign mem_fetch_sig  = mem_fetch_sig_r;
    assign mem_fetch_addr = mem_fetch_addr_r;

    ins_cache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lk_idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .we       (fill_s),
        .wr_idx   (miss_pc_r[3+IDX_W-1:3]),
        .wr_tag   (miss_pc_r[31:3+IDX_W]),
        .wr_data  (mem_fetch_data)
    );

    // Lookup/miss controller with registered response and fetch request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IC_IDLE;
            ins_valid_r      <= 1'b0;
            ins_out_r        <= 32'h0000_0000;
            mem_fetch_sig_r  <= 1'b0;
            mem_fetch_addr_r <= 32'h0000_0000;
            miss_pc_r        <= 32'h0000_0000;
        end else if (rdy) begin
            case (state_r)
                IC_IDLE: begin
                    if (clear) begin
                        ins_valid_r <= 1'b0;
                    end else if (if_req && hit_s) begin
                        ins_valid_r <= 1'b1;
                        ins_out_r   <= sel_word(rd_data_s, if_pc[2]);
                    end else if (if_req) begin
                        miss_pc_r        <= if_pc;
                        mem_fetch_sig_r  <= 1'b1;
                        mem_fetch_addr_r <= {if_pc[31:3], 3'b000};
                        ins_valid_r      <= 1'b0;
                        state_r          <= IC_MISS;
                    end else begin
                        ins_valid_r <= 1'b0;
                    end
                end
                IC_MISS: begin
                    if (mem_fetch_done) begin
                        mem_fetch_sig_r <= 1'b0;
                        ins_out_r       <= sel_word(mem_fetch_data, miss_pc_r[2]);
                        ins_valid_r     <= !clear;
                        state_r         <= IC_IDLE;
                    end else if (clear) begin
                        mem_fetch_sig_r  <= 1'b0;
                        mem_fetch_addr_r <= 32'h0000_0000;
                        ins_valid_r      <= 1'b0;
                        state_r          <= IC_IDLE;
                    end else begin
                        ins_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= IC_IDLE;
                    ins_valid_r     <= 1'b0;
                    mem_fetch_sig_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: directed self-checking bench for ins_cache (LINES=32).
module tb_ins_cache;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, if_req;
    logic [31:0] if_pc;
    logic        if_ready, ins_valid, mem_fetch_sig, mem_fetch_done;
    logic [31:0] ins_out, mem_fetch_addr;
    logic [63:0] mem_fetch_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ins_cache #(.LINES(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clear          (clear),
        .if_req         (if_req),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .ins_valid      (ins_valid),
        .ins_out        (ins_out),
        .mem_fetch_sig  (mem_fetch_sig),
        .mem_fetch_addr (mem_fetch_addr),
        .mem_fetch_done (mem_fetch_done),
        .mem_fetch_data (mem_fetch_data)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are observed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; if_req = 1'b0; if_pc = 32'h0;
        mem_fetch_done = 1'b0; mem_fetch_data = 64'h0;
        tick(); tick();
        rst = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ins_valid); else pass_cnt++;
        chk_cnt++; if (ins_out !== 32'h0) $display("FAIL reset_out: got %h want 0", ins_out); else pass_cnt++;
        chk_cnt++; if (mem_fetch_sig !== 1'b0) $display("FAIL reset_sig: got %b want 0", mem_fetch_sig); else pass_cnt++;
        chk_cnt++; if (mem_fetch_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_fetch_addr); else pass_cnt++;
        chk_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if_ready); else pass_cnt++;
    endtask

    task automatic test_cold_miss();
        if_req = 1'b1; if_pc = 32'h0000_0004;
        tick();
        if_req = 1'b0; if_pc = 32'hDEAD_BEE0;
        chk_cnt++; if (mem_fetch_sig !== 1'b1) $display("FAIL cold_sig: got %b want 1", mem_fetch_sig); else pass_cnt++;
        chk_cnt++; if (mem_fetch_addr !== 32'h0) $display("FAIL cold_addr: got %h want 0", mem_fetch_addr); else pass_cnt++;
        chk_cnt++; if (if_ready !== 1'b0) $display("FAIL cold_ready: got %b want 0", if_ready); else pass_cnt++;
        tick(); tick(); tick();
        chk_cnt++; if (mem_fetch_sig !== 1'b1) $display("FAIL cold_sig_hold: got %b want 1", mem_fetch_sig); else pass_cnt++;
        chk_cnt++; if (ins_valid !== 1'b0) $display("FAIL cold_no_valid: got %b want 0", ins_valid); else pass_cnt++;
        mem_fetch_done = 1'b1; mem_fetch_data = 64'h1111_2222_3333_4444;
        tick();
        mem_fetch_done = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b1) $display("FAIL cold_valid: got %b want 1", ins_valid); else pass_cnt++;
        chk_cnt++; if (ins_out !== 32'h1111_2222) $display("FAIL cold_out: got %h want 11112222", ins_out); else pass_cnt++;
        chk_cnt++; if (mem_fetch_sig !== 1'b0) $display("FAIL cold_sig_drop: got %b want 0", mem_fetch_sig); else pass_cnt++;
        tick();
        chk_cnt++; if (ins_valid !== 1'b0) $display("FAIL cold_pulse: got %b want 0", ins_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        if_req = 1'b1; if_pc = 32'h0000_0000;
        tick();
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'h3333_4444) $display("FAIL hit0: got %b/%h want 1/33334444", ins_valid, ins_out); else pass_cnt++;
        chk_cnt++; if (mem_fetch_sig !== 1'b0) $display("FAIL hit0_sig: got %b want 0", mem_fetch_sig); else pass_cnt++;
        if_pc = 32'h0000_0004;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'h1111_2222) $display("FAIL hit4: got %b/%h want 1/11112222", ins_valid, ins_out); else pass_cnt++;
        tick();
        chk_cnt++; if (ins_valid !== 1'b0) $display("FAIL hit_idle: got %b want 0", ins_valid); else pass_cnt++;
    endtask

    task automatic test_conflict();
        if_req = 1'b1; if_pc = 32'h0000_0100;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b1 || mem_fetch_addr !== 32'h100) $display("FAIL conf_miss: got %b/%h want 1/00000100", mem_fetch_sig, mem_fetch_addr); else pass_cnt++;
        tick();
        mem_fetch_done = 1'b1; mem_fetch_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        mem_fetch_done = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'hCCCC_DDDD) $display("FAIL conf_fill: got %b/%h want 1/ccccdddd", ins_valid, ins_out); else pass_cnt++;
        if_req = 1'b1; if_pc = 32'h0000_0104;
        tick();
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'hAAAA_BBBB) $display("FAIL conf_hit: got %b/%h want 1/aaaabbbb", ins_valid, ins_out); else pass_cnt++;
        if_pc = 32'h0000_0000;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b1 || mem_fetch_addr !== 32'h0 || ins_valid !== 1'b0) $display("FAIL conf_evict: got %b/%h/%b want 1/00000000/0", mem_fetch_sig, mem_fetch_addr, ins_valid); else pass_cnt++;
        mem_fetch_done = 1'b1; mem_fetch_data = 64'h1111_2222_3333_4444;
        tick();
        mem_fetch_done = 1'b0;
        chk_cnt++; if (ins_out !== 32'h3333_4444) $display("FAIL conf_refill: got %h want 33334444", ins_out); else pass_cnt++;
    endtask

    task automatic test_clear();
        if_req = 1'b1; if_pc = 32'h0000_0040;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b1 || mem_fetch_addr !== 32'h40) $display("FAIL clr_miss: got %b/%h want 1/00000040", mem_fetch_sig, mem_fetch_addr); else pass_cnt++;
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b0 || mem_fetch_addr !== 32'h0) $display("FAIL clr_abort: got %b/%h want 0/00000000", mem_fetch_sig, mem_fetch_addr); else pass_cnt++;
        chk_cnt++; if (ins_valid !== 1'b0 || if_ready !== 1'b1) $display("FAIL clr_state: got %b/%b want 0/1", ins_valid, if_ready); else pass_cnt++;
        tick();
        if_req = 1'b1; if_pc = 32'h0000_0040;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b1 || ins_valid !== 1'b0) $display("FAIL clr_still_miss: got %b/%b want 1/0", mem_fetch_sig, ins_valid); else pass_cnt++;
        // done and clear together: fill happens, response suppressed
        mem_fetch_done = 1'b1; clear = 1'b1; mem_fetch_data = 64'h5555_6666_7777_8888;
        tick();
        mem_fetch_done = 1'b0; clear = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b0 || mem_fetch_sig !== 1'b0) $display("FAIL clr_done: got %b/%b want 0/0", ins_valid, mem_fetch_sig); else pass_cnt++;
        if_req = 1'b1; if_pc = 32'h0000_0044;
        tick();
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'h5555_6666 || mem_fetch_sig !== 1'b0) $display("FAIL clr_done_hit: got %b/%h/%b want 1/55556666/0", ins_valid, ins_out, mem_fetch_sig); else pass_cnt++;
        clear = 1'b1;
        tick();
        clear = 1'b0; if_req = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b0) $display("FAIL clr_idle_req: got %b want 0", ins_valid); else pass_cnt++;
    endtask

    task automatic test_rdy();
        if_req = 1'b1; if_pc = 32'h0000_0080;
        tick();
        rdy = 1'b0; if_pc = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cnt++; if (mem_fetch_sig !== 1'b1 || mem_fetch_addr !== 32'h80 || if_ready !== 1'b0) $display("FAIL rdy_hold%0d: got %b/%h/%b want 1/00000080/0", i, mem_fetch_sig, mem_fetch_addr, if_ready); else pass_cnt++;
        end
        rdy = 1'b1; if_req = 1'b0;
        tick();
        mem_fetch_done = 1'b1; mem_fetch_data = 64'h9999_0000_1234_5678;
        tick();
        mem_fetch_done = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'h1234_5678) $display("FAIL rdy_fill: got %b/%h want 1/12345678", ins_valid, ins_out); else pass_cnt++;
        if_req = 1'b1; if_pc = 32'h0000_0084;
        tick();
        rdy = 1'b0; if_req = 1'b0;
        tick();
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'h9999_0000) $display("FAIL rdy_freeze: got %b/%h want 1/99990000", ins_valid, ins_out); else pass_cnt++;
        rdy = 1'b1;
        tick();
        chk_cnt++; if (ins_valid !== 1'b0) $display("FAIL rdy_release: got %b want 0", ins_valid); else pass_cnt++;
    endtask

    task automatic test_high_addr();
        if_req = 1'b1; if_pc = 32'hFFFF_FFFC;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (mem_fetch_addr !== 32'hFFFF_FFF8) $display("FAIL high_addr: got %h want fffffff8", mem_fetch_addr); else pass_cnt++;
        mem_fetch_done = 1'b1; mem_fetch_data = 64'hCAFE_F00D_0BAD_BEEF;
        tick();
        mem_fetch_done = 1'b0;
        chk_cnt++; if (ins_valid !== 1'b1 || ins_out !== 32'hCAFE_F00D) $display("FAIL high_fill: got %b/%h want 1/cafef00d", ins_valid, ins_out); else pass_cnt++;
    endtask

    task automatic test_rst_mid_miss();
        if_req = 1'b1; if_pc = 32'h0000_0200;
        tick();
        if_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b0 || mem_fetch_addr !== 32'h0 || if_ready !== 1'b1 || ins_out !== 32'h0) $display("FAIL rst_mid: got %b/%h/%b/%h want 0/00000000/1/00000000", mem_fetch_sig, mem_fetch_addr, if_ready, ins_out); else pass_cnt++;
        if_req = 1'b1; if_pc = 32'h0000_0000;
        tick();
        if_req = 1'b0;
        chk_cnt++; if (mem_fetch_sig !== 1'b1 || ins_valid !== 1'b0) $display("FAIL rst_invalidate: got %b/%b want 1/0", mem_fetch_sig, ins_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_clear();
        test_rdy();
        test_high_addr();
        test_rst_mid_miss();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
